// File: rtl/lsram_dp_pkg.sv
// Shared constants and helpers for the byte-writable dual-port LSRAM buffer.
// Merge helpers work on a maximum-width word; callers extend and truncate to their own width.
package lsram_dp_pkg;

  localparam int COLL_READ_OLD    = 0;
  localparam int COLL_WRITE_FIRST = 1;

  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_BYTES      = MAX_DATA_WIDTH / 8;

  typedef logic [MAX_DATA_WIDTH-1:0] word_max_t;
  typedef logic [MAX_BYTES-1:0]      be_max_t;

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

  function automatic word_max_t merge_be(input word_max_t old_word,
                                         input word_max_t new_word,
                                         input be_max_t   be);
    word_max_t merged;
    merged = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/lsram_dp_bytewr_pipe_if.sv
// Write/read bus of the dual-port buffer. The master drives requests; the
// slave (the buffer) returns read data and its valid strobe.
interface lsram_dp_bytewr_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  W_EN;
  logic [ADDR_WIDTH-1:0] W_ADDR;
  logic [BE_WIDTH-1:0]   W_BE;
  logic [DATA_WIDTH-1:0] W_DATA;
  logic                  R_EN;
  logic [ADDR_WIDTH-1:0] R_ADDR;
  logic [DATA_WIDTH-1:0] R_DATA;
  logic                  R_VALID;

  modport master (
    output W_EN, W_ADDR, W_BE, W_DATA, R_EN, R_ADDR,
    input  R_DATA, R_VALID
  );

  modport slave (
    input  W_EN, W_ADDR, W_BE, W_DATA, R_EN, R_ADDR,
    output R_DATA, R_VALID
  );
endinterface

// File: rtl/lsram_dp_core.sv
// Storage core: byte-writable array with a registered read port and an
// optional write-first bypass on same-address collisions.
module lsram_dp_core
  import lsram_dp_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int COLLISION_MODE = COLL_READ_OLD
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            w_en,
  input  logic [ADDR_WIDTH-1:0]           w_addr,
  input  logic [bytes_of(DATA_WIDTH)-1:0] w_be,
  input  logic [DATA_WIDTH-1:0]           w_data,
  input  logic                            r_en,
  input  logic [ADDR_WIDTH-1:0]           r_addr,
  output logic [DATA_WIDTH-1:0]           rd_q
);

  localparam int NUM_BYTES = bytes_of(DATA_WIDTH);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] stored;
  logic [DATA_WIDTH-1:0] rd_next;
  logic                  collide;

  assign stored  = mem[r_addr];
  assign collide = w_en && (w_addr == r_addr);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_next = stored;
    if ((COLLISION_MODE == COLL_WRITE_FIRST) && collide) begin
      rd_next = DATA_WIDTH'(merge_be(word_max_t'(stored), word_max_t'(w_data),
                                     be_max_t'(w_be)));
    end
  end

  // NOTE: the array is deliberately left out of reset so it stays inferable as block RAM;
  // writes are still suppressed while rst_n is low.
  always_ff @(posedge clk) begin
    if (w_en && rst_n) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (w_be[i]) mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so same-edge reads see pre-write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (r_en) begin
      rd_q <= rd_next;
    end
  end

endmodule

// File: rtl/lsram_dp_bytewr_pipe.sv
// Simple-dual-port LSRAM buffer with byte enables, 1- or 2-cycle read latency
// and a one-cycle read-valid strobe. Read data holds between reads.
module lsram_dp_bytewr_pipe
  import lsram_dp_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int RD_LATENCY     = 1,
  parameter int COLLISION_MODE = COLL_READ_OLD
) (
  input logic                  CLK,
  input logic                  RESETN,
  lsram_dp_bytewr_pipe_if.slave bus
);

  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
    $error("RD_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (DATA_WIDTH > MAX_DATA_WIDTH) begin : g_too_wide
    $error("DATA_WIDTH exceeds MAX_DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0] rd_stage1;
  logic                  valid_stage1;

  lsram_dp_core #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .COLLISION_MODE (COLLISION_MODE)
  ) u_core (
    .clk    (CLK),
    .rst_n  (RESETN),
    .w_en   (bus.W_EN),
    .w_addr (bus.W_ADDR),
    .w_be   (bus.W_BE),
    .w_data (bus.W_DATA),
    .r_en   (bus.R_EN),
    .r_addr (bus.R_ADDR),
    .rd_q   (rd_stage1)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      valid_stage1 <= 1'b0;
    end else begin
      valid_stage1 <= bus.R_EN;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rd_stage2;
    logic                  valid_stage2;

    // The second register only loads behind a real read so idle cycles keep the last word.
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        rd_stage2    <= '0;
        valid_stage2 <= 1'b0;
      end else begin
        valid_stage2 <= valid_stage1;
        if (valid_stage1) rd_stage2 <= rd_stage1;
      end
    end

    assign bus.R_DATA  = rd_stage2;
    assign bus.R_VALID = valid_stage2;
  end else begin : g_lat1
    assign bus.R_DATA  = rd_stage1;
    assign bus.R_VALID = valid_stage1;
  end

  a_no_x_ctrl : assert property (@(posedge CLK) disable iff (!RESETN)
                                 !$isunknown({bus.W_EN, bus.R_EN, RESETN}))
    else $error("X on W_EN, R_EN or RESETN");

endmodule

// File: tb/tb_lsram_dp_bytewr_pipe.sv
// Scoreboard bench for lsram_dp_bytewr_pipe: four instances cover both read
// latencies and both collision policies, all fed by the same stimulus.
module tb_lsram_dp_bytewr_pipe;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;
  localparam int NCFG  = 4;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          w_en   = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [NB-1:0] w_be   = '0;
  logic [DW-1:0] w_data = '0;
  logic          r_en   = 1'b0;
  logic [AW-1:0] r_addr = '0;

  logic [DW-1:0] r_data_a  [NCFG];
  logic          r_valid_a [NCFG];

  exp_t          sb    [NCFG][$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] held  [NCFG];

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  bit done        = 1'b0;

  function automatic int lat_of(input int cfg);
    return (cfg < 2) ? 1 : 2;
  endfunction

  function automatic int mode_of(input int cfg);
    return cfg % 2;
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    lsram_dp_bytewr_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    assign bus.W_EN   = w_en;
    assign bus.W_ADDR = w_addr;
    assign bus.W_BE   = w_be;
    assign bus.W_DATA = w_data;
    assign bus.R_EN   = r_en;
    assign bus.R_ADDR = r_addr;
    assign r_data_a[g]  = bus.R_DATA;
    assign r_valid_a[g] = bus.R_VALID;

    lsram_dp_bytewr_pipe #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .RD_LATENCY     ((g < 2) ? 1 : 2),
      .COLLISION_MODE (g % 2)
    ) dut (
      .CLK    (clk),
      .RESETN (rst_n),
      .bus    (bus)
    );
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus. The expected read result is derived from the
  // reference memory before this cycle's write is applied to it.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [NB-1:0] be,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
    exp_t          e;
    logic [DW-1:0] old_word;
    logic [DW-1:0] new_word;
    w_en   = we;
    w_addr = wa;
    w_be   = be;
    w_data = wd;
    r_en   = re;
    r_addr = ra;
    if (re && rst_n) begin
      old_word = model[ra];
      new_word = old_word;
      if (we && (wa == ra)) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) new_word[8*b +: 8] = wd[8*b +: 8];
        end
      end
      for (int i = 0; i < NCFG; i++) begin
        e.due  = cyc + lat_of(i);
        e.data = (mode_of(i) == 1) ? new_word : old_word;
        sb[i].push_back(e);
      end
    end
    if (we && rst_n) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) model[wa][8*b +: 8] = wd[8*b +: 8];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NCFG; i++) begin
      if (!rst_n) begin
        check($sformatf("reset_rdata[%0d]", i), r_data_a[i], '0);
        check($sformatf("reset_rvalid[%0d]", i), DW'(r_valid_a[i]), '0);
        sb[i].delete();
        held[i] = '0;
      end else if (r_valid_a[i]) begin
        if (sb[i].size() == 0) begin
          check($sformatf("unexpected_rvalid[%0d]", i), DW'(r_valid_a[i]), '0);
        end else begin
          e = sb[i].pop_front();
          check($sformatf("rvalid_cycle[%0d]", i), DW'(cyc), DW'(e.due));
          check($sformatf("rdata[%0d]", i), r_data_a[i], e.data);
          held[i] = e.data;
        end
      end else begin
        if ((sb[i].size() != 0) && (sb[i][0].due <= cyc)) begin
          e = sb[i].pop_front();
          check($sformatf("missing_rvalid[%0d]", i), DW'(r_valid_a[i]), DW'(1));
        end
        check($sformatf("hold_rdata[%0d]", i), r_data_a[i], held[i]);
      end
    end
    if (done || (cyc > 20000)) begin
      check("run_completed", DW'(done), DW'(1));
      for (int i = 0; i < NCFG; i++) begin
        check($sformatf("drained[%0d]", i), DW'(sb[i].size()), '0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    // NOTE: the bench drives DUT inputs with blocking assignments one time unit after the edge.
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with reads requested: nothing may come out.
    for (int k = 0; k < 3; k++) step(1'b0, '0, '0, '0, 1'b1, AW'(k));
    rst_n = 1'b1;
    idle(2);

    // Fill every address, then stream all of them back-to-back.
    for (int a = 0; a < DEPTH; a++) step(1'b1, AW'(a), '1, DW'(a * 3), 1'b0, '0);
    for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, 1'b1, AW'(a));
    idle(3);

    // Partial byte-enable overwrite of address 5.
    step(1'b1, AW'(5), 4'b1111, 32'hAABBCCDD, 1'b0, '0);
    step(1'b1, AW'(5), 4'b0101, 32'h11223344, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, AW'(5));
    idle(3);

    // Same-edge collision on address 9, then a follow-up read.
    step(1'b1, AW'(9), 4'b1111, 32'h00000000, 1'b0, '0);
    step(1'b1, AW'(9), 4'b0011, 32'hFFFFFFFF, 1'b1, AW'(9));
    step(1'b0, '0, '0, '0, 1'b1, AW'(9));
    idle(3);

    // Read data must hold while the source address is rewritten.
    step(1'b1, AW'(3), 4'b1111, 32'h5A5A5A5A, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, AW'(3));
    for (int k = 0; k < 10; k++) step(1'b1, AW'(3), 4'b1111, 32'h0, 1'b0, '0);

    // Random traffic concentrated on a few addresses to provoke collisions.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), NB'($urandom()),
           DW'($urandom()), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
    end
    idle(3);

    // Reset arrives while a read is in flight.
    step(1'b0, '0, '0, '0, 1'b1, AW'(20));
    #1 rst_n = 1'b0;
    step(1'b1, AW'(20), '1, 32'hDEADBEEF, 1'b1, AW'(20));
    idle(2);
    rst_n = 1'b1;
    idle(3);
    step(1'b0, '0, '0, '0, 1'b1, AW'(20));
    idle(4);

    done = 1'b1;
  end

endmodule
